// File: rtl/spi_master_fifo.sv
// Memory-mapped SPI master with TX/RX FIFOs, programmable SCLK divider,
// all four CPOL/CPHA modes and a parametrised word width.
module spi_master_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DIVW  = 8
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  input  logic        cs,
  input  logic        we,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        ssn_out
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned HPW = $clog2(2 * DW);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_DIV    = 2'd3;

  logic [1:0]      state, state_d;
  logic [DIVW-1:0] cnt, cnt_d, div;
  logic [HPW-1:0]  hp, hp_d;
  logic            sclk_d, mosi_d, ssn_d;
  logic [DW-1:0]   tx_sh, tx_sh_d, rx_sh, rx_sh_d, tx_next, rx_next, rx_word;
  logic [3:0]      ctrl, ctrl_d;
  logic            wr_q, rd_q, wr_stb, rd_stb, tick, busy;
  logic            tx_ovf, rx_ovr;
  logic            tx_push_req, tx_push, tx_pop, rx_push_req, rx_push, rx_pop;
  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic [PW-1:0]   tx_wr, tx_rd, rx_wr, rx_rd;
  logic [DW-1:0]   tx_mem [DEPTH];
  logic [DW-1:0]   rx_mem [DEPTH];
  logic [DW-1:0]   tx_head, rx_head;
  logic [15:0]     status;
  logic            unused_din;

  function automatic logic first_bit(input logic [DW-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DW-1];
  endfunction

  // An access acts only in the first cycle of cs with a given direction
  assign wr_stb = cs & we & ~wr_q;
  assign rd_stb = cs & ~we & ~rd_q;
  assign busy   = (state != IDLE);
  assign tick   = (cnt == div);
  assign unused_din = ^din;

  assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
  assign tx_empty = (tx_wr == tx_rd);
  assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign rx_empty = (rx_wr == rx_rd);
  assign tx_head  = tx_mem[tx_rd[AW-1:0]];
  assign rx_head  = rx_mem[rx_rd[AW-1:0]];

  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
  assign tx_push_req = wr_stb && (addr == A_DATA);
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign rx_pop      = rd_stb && (addr == A_DATA) && !rx_empty;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);

  assign status = {9'd0, tx_ovf, rx_ovr, rx_empty, rx_full, tx_empty, tx_full, busy};

  // Mode bits are frozen while busy; enable stays writable so a transfer can be stopped
  always_comb begin
    ctrl_d = ctrl;
    if (wr_stb && (addr == A_CTRL)) begin
      ctrl_d = busy ? {ctrl[3:1], din[0]} : din[3:0];
    end
  end

  always_comb begin
    dout = '0;
    if (cs && !we) begin
      case (addr)
        A_DATA:   dout = rx_empty ? 16'd0 : 16'(rx_head);
        A_STATUS: dout = status;
        A_CTRL:   dout = {12'd0, ctrl};
        A_DIV:    dout = 16'(div);
      endcase
    end
  end

  assign tx_next = ctrl[3] ? (tx_sh >> 1) : (tx_sh << 1);
  assign rx_next = ctrl[3] ? {miso, rx_sh[DW-1:1]} : {rx_sh[DW-2:0], miso};
  assign rx_word = ctrl[2] ? rx_next : rx_sh;

  always_comb begin
    state_d     = state;
    cnt_d       = tick ? '0 : cnt + DIVW'(1);
    hp_d        = hp;
    sclk_d      = sclk;
    mosi_d      = mosi;
    ssn_d       = ssn_out;
    tx_sh_d     = tx_sh;
    rx_sh_d     = rx_sh;
    tx_pop      = 1'b0;
    rx_push_req = 1'b0;
    case (state)
      IDLE: begin
        cnt_d  = '0;
        sclk_d = ctrl_d[1];
        ssn_d  = 1'b1;
        if (ctrl_d[0] && !tx_empty) begin
          state_d = SETUP;
          tx_pop  = 1'b1;
          tx_sh_d = tx_head;
          mosi_d  = first_bit(tx_head, ctrl_d[3]);
          ssn_d   = 1'b0;
        end
      end
      SETUP: begin
        sclk_d = ctrl[1];
        if (tick) begin
          state_d = SHIFT;
          hp_d    = '0;
        end
      end
      SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk;
          hp_d   = hp + HPW'(1);
          // Even hp count means this toggle is a leading edge
          if (!hp[0]) begin
            if (ctrl[2]) begin
              mosi_d  = first_bit(tx_sh, ctrl[3]);
              tx_sh_d = tx_next;
            end else begin
              rx_sh_d = rx_next;
            end
          end else begin
            if (ctrl[2]) begin
              rx_sh_d = rx_next;
            end else begin
              tx_sh_d = tx_next;
              mosi_d  = first_bit(tx_next, ctrl[3]);
            end
          end
          if (hp == HPW'(2 * DW - 1)) begin
            state_d     = HOLD;
            rx_push_req = 1'b1;
          end
        end
      end
      HOLD: begin
        sclk_d = ctrl[1];
        if (tick) begin
          if (ctrl[0] && !tx_empty) begin
            state_d = SHIFT;
            hp_d    = '0;
            tx_pop  = 1'b1;
            tx_sh_d = tx_head;
            mosi_d  = first_bit(tx_head, ctrl[3]);
          end else begin
            state_d = IDLE;
            ssn_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hp      <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ssn_out <= 1'b1;
      tx_sh   <= '0;
      rx_sh   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      hp      <= hp_d;
      sclk    <= sclk_d;
      mosi    <= mosi_d;
      ssn_out <= ssn_d;
      tx_sh   <= tx_sh_d;
      rx_sh   <= rx_sh_d;
    end
  end

  // Bus-side registers, FIFO pointers and sticky flags (set wins over clear)
  always_ff @(posedge clock_in) begin
    if (reset) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      ctrl   <= '0;
      div    <= '0;
      tx_ovf <= 1'b0;
      rx_ovr <= 1'b0;
      tx_wr  <= '0;
      tx_rd  <= '0;
      rx_wr  <= '0;
      rx_rd  <= '0;
    end else begin
      wr_q <= cs & we;
      rd_q <= cs & ~we;
      ctrl <= ctrl_d;
      if (wr_stb && (addr == A_DIV) && !busy) div <= DIVW'(din);
      if (tx_push_req && !tx_push) tx_ovf <= 1'b1;
      else if (wr_stb && (addr == A_STATUS) && din[6]) tx_ovf <= 1'b0;
      if (rx_push_req && !rx_push) rx_ovr <= 1'b1;
      else if (wr_stb && (addr == A_STATUS) && din[5]) rx_ovr <= 1'b0;
      if (tx_push) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PW'(1);
      if (rx_push) rx_wr <= rx_wr + PW'(1);
      if (rx_pop)  rx_rd <= rx_rd + PW'(1);
    end
  end

  always_ff @(posedge clock_in) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= din[DW-1:0];
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_word;
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
// Self-checking bench for spi_master_fifo: register table, directed SPI
// sequences and randomized loopback transfers against a transaction-level model.
module tb_spi_master_fifo;

  localparam int unsigned DW = 8;
  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_DIV = 2'd3;
  localparam logic [15:0] ST_BUSY = 16'h01, ST_TXFULL = 16'h02, ST_TXEMPTY = 16'h04,
                          ST_RXFULL = 16'h08, ST_RXEMPTY = 16'h10, ST_RXOVR = 16'h20,
                          ST_TXOVF = 16'h40;

  logic clock_in, reset, cs, we, sclk, mosi, miso, ssn_out;
  logic [1:0]  addr;
  logic [15:0] din, dout;

  int passed, total;

  // Window monitor: ssn_out low-time, rising sclk count, words seen by a slave
  bit m_cpol, m_cpha, m_lsb;
  int low_q[$];
  int rise_q[$];
  logic [DW-1:0] word_q[$];

  spi_master_fifo #(.DW(DW), .DEPTH(4), .DIVW(8)) dut (
    .clock_in(clock_in), .reset(reset), .addr(addr), .din(din), .dout(dout),
    .cs(cs), .we(we), .sclk(sclk), .mosi(mosi), .miso(miso), .ssn_out(ssn_out)
  );

  assign miso = mosi;

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  initial begin
    logic prev_sclk, prev_ssn, lead;
    logic [DW-1:0] sh;
    int low_cnt, rise_cnt, bit_cnt;
    prev_sclk = 1'b0; prev_ssn = 1'b1; sh = '0;
    low_cnt = 0; rise_cnt = 0; bit_cnt = 0;
    forever begin
      @(negedge clock_in);
      if (ssn_out === 1'b0) begin
        low_cnt++;
        if (sclk && !prev_sclk) rise_cnt++;
        if (sclk !== prev_sclk) begin
          lead = (prev_sclk == m_cpol);
          if (lead != m_cpha) begin
            sh = m_lsb ? {mosi, sh[DW-1:1]} : {sh[DW-2:0], mosi};
            bit_cnt++;
            if (bit_cnt == DW) begin
              word_q.push_back(sh);
              bit_cnt = 0;
            end
          end
        end
      end else if (prev_ssn === 1'b0) begin
        low_q.push_back(low_cnt);
        rise_q.push_back(rise_cnt);
        low_cnt = 0; rise_cnt = 0; bit_cnt = 0;
      end
      prev_sclk = sclk;
      prev_ssn  = ssn_out;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic bus(input logic c, input logic w, input logic [1:0] a, input logic [15:0] d,
                     output logic [15:0] r);
    @(negedge clock_in);
    cs = c; we = w; addr = a; din = d;
    #1 r = dout;
    @(negedge clock_in);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    logic [15:0] r;
    bus(1'b1, 1'b1, a, d, r);
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [15:0] exp);
    logic [15:0] r;
    bus(1'b1, 1'b0, a, 16'h0, r);
    check(name, r, exp);
  endtask

  task automatic clear_mon();
    low_q.delete(); rise_q.delete(); word_q.delete();
  endtask

  task automatic set_mode(input bit cpol, input bit cpha, input bit lsb);
    m_cpol = cpol; m_cpha = cpha; m_lsb = lsb;
  endtask

  task automatic wait_windows(input int n, input int budget);
    int i;
    i = 0;
    while (low_q.size() < n && i < budget) begin
      @(negedge clock_in);
      i++;
    end
    check("window_wait", low_q.size(), n);
  endtask

  task automatic do_reset();
    @(negedge clock_in);
    reset = 1'b1; cs = 1'b0; we = 1'b0;
    repeat (2) @(negedge clock_in);
    reset = 1'b0;
    clear_mon();
  endtask

  typedef struct {
    logic        c;
    logic        w;
    logic [1:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[14];
  logic [DW-1:0] exp_q[$];

  initial begin
    logic [15:0] r;
    passed = 0; total = 0;
    cs = 1'b0; we = 1'b0; addr = '0; din = '0; reset = 1'b1;
    set_mode(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clock_in);
    reset = 1'b0;
    clear_mon();

    // Reset values and register access table
    check("reset_sclk", sclk, 1'b0);
    check("reset_ssn", ssn_out, 1'b1);
    check("reset_mosi", mosi, 1'b0);
    vt[0]  = '{1'b1, 1'b0, A_STATUS, 16'h0000, ST_TXEMPTY | ST_RXEMPTY};
    vt[1]  = '{1'b1, 1'b0, A_DATA,   16'h0000, 16'h0000};
    vt[2]  = '{1'b1, 1'b0, A_CTRL,   16'h0000, 16'h0000};
    vt[3]  = '{1'b1, 1'b0, A_DIV,    16'h0000, 16'h0000};
    vt[4]  = '{1'b1, 1'b1, A_DIV,    16'h005A, 16'h0000};
    vt[5]  = '{1'b1, 1'b0, A_DIV,    16'h0000, 16'h005A};
    vt[6]  = '{1'b1, 1'b1, A_CTRL,   16'hFFF6, 16'h0000};
    vt[7]  = '{1'b1, 1'b0, A_CTRL,   16'h0000, 16'h0006};
    vt[8]  = '{1'b0, 1'b0, A_CTRL,   16'h0000, 16'h0000};
    vt[9]  = '{1'b1, 1'b1, A_STATUS, 16'h0060, 16'h0000};
    vt[10] = '{1'b1, 1'b0, A_STATUS, 16'h0000, ST_TXEMPTY | ST_RXEMPTY};
    vt[11] = '{1'b1, 1'b1, A_CTRL,   16'h0000, 16'h0000};
    vt[12] = '{1'b1, 1'b1, A_DIV,    16'h0000, 16'h0000};
    vt[13] = '{1'b1, 1'b0, A_DIV,    16'h0000, 16'h0000};
    for (int i = 0; i < 14; i++) begin
      bus(vt[i].c, vt[i].w, vt[i].a, vt[i].d, r);
      check($sformatf("reg_vec%0d", i), r, vt[i].exp);
    end

    // Mode 0 loopback, DIV=0
    set_mode(1'b0, 1'b0, 1'b0);
    wr(A_CTRL, 16'h0001);
    wr(A_DATA, 16'h00A5);
    check("start_before", ssn_out, 1'b1);
    @(negedge clock_in);
    check("start_latency", ssn_out, 1'b0);
    wait_windows(1, 500);
    check("m0_low_cycles", low_q[0], 18);
    check("m0_rises", rise_q[0], 8);
    check("m0_mosi_word", word_q[0], 8'hA5);
    rd_check("m0_rx", A_DATA, 16'h00A5);
    rd_check("m0_status", A_STATUS, ST_TXEMPTY | ST_RXEMPTY);

    // Mode 3, lsb first, DIV=2
    wr(A_CTRL, 16'h000E);
    wr(A_DIV, 16'h0002);
    check("m3_idle_high", sclk, 1'b1);
    set_mode(1'b1, 1'b1, 1'b1);
    clear_mon();
    wr(A_DATA, 16'h003C);
    wr(A_CTRL, 16'h000F);
    wait_windows(1, 500);
    check("m3_low_cycles", low_q[0], 18 * 3);
    check("m3_mosi_word", word_q[0], 8'h3C);
    check("m3_rises", rise_q[0], 8);
    check("m3_idle_after", sclk, 1'b1);
    rd_check("m3_rx", A_DATA, 16'h003C);

    // TX overflow then back-to-back drain
    do_reset();
    set_mode(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) wr(A_DATA, 16'(i));
    rd_check("ovf_status", A_STATUS, ST_TXFULL | ST_TXOVF | ST_RXEMPTY);
    wr(A_CTRL, 16'h0001);
    wait_windows(1, 1000);
    check("b2b_low_cycles", low_q[0], 1 + 4 * (2 * DW + 1));
    check("b2b_rises", rise_q[0], 4 * DW);
    check("b2b_word_count", word_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("b2b_word%0d", i), word_q[i], 32'(i + 1));
    rd_check("rxfull_status", A_STATUS, ST_TXOVF | ST_RXFULL | ST_TXEMPTY);
    wr(A_STATUS, 16'h0040);
    rd_check("ovf_clear", A_STATUS, ST_RXFULL | ST_TXEMPTY);

    // RX overrun
    clear_mon();
    wr(A_DATA, 16'h0005);
    wait_windows(1, 500);
    rd_check("ovr_status", A_STATUS, ST_RXOVR | ST_RXFULL | ST_TXEMPTY);
    for (int i = 1; i <= 4; i++) rd_check($sformatf("ovr_rd%0d", i), A_DATA, 16'(i));
    rd_check("ovr_rd_empty", A_DATA, 16'h0000);
    rd_check("ovr_status2", A_STATUS, ST_RXOVR | ST_TXEMPTY | ST_RXEMPTY);
    wr(A_STATUS, 16'h0020);
    rd_check("ovr_clear", A_STATUS, ST_TXEMPTY | ST_RXEMPTY);

    // Read strobe held for 4 cycles pops once
    clear_mon();
    wr(A_DATA, 16'h0011);
    wr(A_DATA, 16'h0022);
    wait_windows(1, 500);
    @(negedge clock_in);
    cs = 1'b1; we = 1'b0; addr = A_DATA;
    #1 check("hold_first", dout, 16'h0011);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_in);
      #1 check($sformatf("hold_next%0d", i), dout, 16'h0022);
    end
    @(negedge clock_in);
    cs = 1'b0;
    rd_check("hold_status", A_STATUS, ST_TXEMPTY);
    rd_check("hold_remain", A_DATA, 16'h0022);
    rd_check("hold_empty", A_DATA, 16'h0000);

    // Write strobe held for 3 cycles pushes once
    wr(A_CTRL, 16'h0000);
    @(negedge clock_in);
    cs = 1'b1; we = 1'b1; addr = A_DATA; din = 16'h0077;
    repeat (3) @(negedge clock_in);
    cs = 1'b0; we = 1'b0;
    rd_check("wrhold_status", A_STATUS, ST_RXEMPTY);
    clear_mon();
    wr(A_CTRL, 16'h0001);
    wait_windows(1, 500);
    check("wrhold_low", low_q[0], 18);
    check("wrhold_words", word_q.size(), 1);
    rd_check("wrhold_rx", A_DATA, 16'h0077);

    // Reset halfway through a word (cpol=1, DIV=3)
    wr(A_DIV, 16'h0003);
    wr(A_CTRL, 16'h0003);
    set_mode(1'b1, 1'b0, 1'b0);
    clear_mon();
    wr(A_DATA, 16'h005A);
    repeat (36) @(negedge clock_in);
    check("mid_busy", ssn_out, 1'b0);
    reset = 1'b1;
    @(negedge clock_in);
    check("mid_rst_sclk", sclk, 1'b0);
    check("mid_rst_ssn", ssn_out, 1'b1);
    check("mid_rst_mosi", mosi, 1'b0);
    reset = 1'b0;
    rd_check("mid_rst_status", A_STATUS, ST_TXEMPTY | ST_RXEMPTY);
    rd_check("mid_rst_ctrl", A_CTRL, 16'h0000);
    rd_check("mid_rst_div", A_DIV, 16'h0000);

    // CTRL/DIV writes during busy are ignored
    wr(A_DIV, 16'h0003);
    wr(A_CTRL, 16'h0001);
    set_mode(1'b0, 1'b0, 1'b0);
    clear_mon();
    wr(A_DATA, 16'h0096);
    repeat (10) @(negedge clock_in);
    wr(A_CTRL, 16'h000F);
    wr(A_DIV, 16'h0007);
    rd_check("busy_ctrl", A_CTRL, 16'h0001);
    rd_check("busy_div", A_DIV, 16'h0003);
    wait_windows(1, 1000);
    check("busy_low", low_q[0], 18 * 4);
    check("busy_word", word_q[0], 8'h96);
    rd_check("busy_rx", A_DATA, 16'h0096);

    // Clearing enable mid-word finishes the word and keeps the rest queued
    wr(A_CTRL, 16'h0000);
    for (int i = 0; i < 3; i++) wr(A_DATA, 16'h0031 + 16'(i));
    clear_mon();
    wr(A_CTRL, 16'h0001);
    repeat (6) @(negedge clock_in);
    wr(A_CTRL, 16'h0000);
    wait_windows(1, 1000);
    check("en_clr_low", low_q[0], 18 * 4);
    check("en_clr_words", word_q.size(), 1);
    rd_check("en_clr_status", A_STATUS, 16'h0000);
    clear_mon();
    wr(A_CTRL, 16'h0001);
    wait_windows(1, 1000);
    check("en_resume_low", low_q[0], (1 + 2 * (2 * DW + 1)) * 4);
    for (int i = 0; i < 3; i++) rd_check($sformatf("en_rd%0d", i), A_DATA, 16'h0031 + 16'(i));

    // Randomized modes, dividers and bursts against the transaction model
    for (int it = 0; it < 12; it++) begin
      bit cpol, cpha, lsb;
      int dv, n;
      logic [DW-1:0] w;
      logic [15:0] mode;
      cpol = 1'($urandom); cpha = 1'($urandom); lsb = 1'($urandom);
      dv = int'($urandom_range(0, 3));
      n  = int'($urandom_range(1, 4));
      mode = {12'd0, lsb, cpha, cpol, 1'b0};
      wr(A_CTRL, mode);
      wr(A_DIV, 16'(dv));
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
        w = DW'($urandom);
        exp_q.push_back(w);
        wr(A_DATA, 16'(w));
      end
      set_mode(cpol, cpha, lsb);
      clear_mon();
      wr(A_CTRL, mode | 16'h0001);
      wait_windows(1, 2000);
      check($sformatf("rnd%0d_low", it), low_q[0], (1 + n * (2 * DW + 1)) * (dv + 1));
      check($sformatf("rnd%0d_rises", it), rise_q[0], n * DW);
      check($sformatf("rnd%0d_nwords", it), word_q.size(), n);
      for (int k = 0; k < n; k++) begin
        check($sformatf("rnd%0d_mosi%0d", it, k), word_q[k], exp_q[k]);
        rd_check($sformatf("rnd%0d_rx%0d", it, k), A_DATA, 16'(exp_q[k]));
      end
      rd_check($sformatf("rnd%0d_status", it), A_STATUS, ST_TXEMPTY | ST_RXEMPTY);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
